// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared widths and constants for the MIPS pipeline MEM/WB
//                boundary, register file and writeback stage.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Register $0 is architecturally hardwired to zero
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // MEM/WB pipeline register field widths
    localparam int MEMWB_CTRL_W = 3;        // RegWr, RegDst, MemToReg
    localparam int MEMWB_REG_W  = ADDR_W;   // rt and rd fields
    localparam int MEMWB_DATA_W = DATA_W;   // Dout and Result
    localparam int MEMWB_W      = MEMWB_CTRL_W + 2 * MEMWB_REG_W + 2 * MEMWB_DATA_W;

    typedef struct packed {
        logic                    RegWr;
        logic                    RegDst;
        logic                    MemToReg;
        logic [MEMWB_REG_W-1:0]  rt;
        logic [MEMWB_REG_W-1:0]  rd;
        logic [MEMWB_DATA_W-1:0] Dout;
        logic [MEMWB_DATA_W-1:0] Result;
    } memwb_t;

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : Register array with two combinational read ports and one
//                synchronous write port. $0 reads as zero; a read that hits
//                the address being written this cycle returns the write data.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_2r1w #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_ra1,
    input  logic [ADDR_W-1:0] i_ra2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2
);
    import pipe_pkg::*;

    localparam int                c_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO  = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [c_DEPTH];

    logic w_wr_ok;
    assign w_wr_ok = i_we & (i_waddr != c_ZERO);

    // Clear the whole array on reset, otherwise commit one write per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Port 1: $0 forced to zero, then write-before-read bypass, then array
    always_comb begin
        o_rd1 = r_regs[i_ra1];
        if (i_ra1 == c_ZERO) begin
            o_rd1 = '0;
        end else if (w_wr_ok && (i_ra1 == i_waddr)) begin
            o_rd1 = i_wdata;
        end
    end

    // Port 2: same priority as port 1
    always_comb begin
        o_rd2 = r_regs[i_ra2];
        if (i_ra2 == c_ZERO) begin
            o_rd2 = '0;
        end else if (w_wr_ok && (i_ra2 == i_waddr)) begin
            o_rd2 = i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Writeback stage plus architectural register file. Selects
//                destination and write data from MEM/WB, commits into the
//                register file, exports the write to forwarding, and keeps a
//                saturating count of committed writes.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWr,
    input  logic              RegDst,
    input  logic              MemToReg,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] Dout,
    input  logic [DATA_W-1:0] Result,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  commit_cnt
);
    import pipe_pkg::*;

    localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(REG_ZERO);

    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we_eff;
    logic [CNT_W-1:0]  r_commit_cnt;

    // Destination / data selection; writes to $0 and writes during reset
    // are squashed so they are neither committed, counted nor forwarded
    assign w_waddr  = RegDst   ? rd   : rt;
    assign w_wdata  = MemToReg ? Dout : Result;
    assign w_we_eff = RegWr & (w_waddr != c_ZERO) & ~rst;

    assign wb_we      = w_we_eff;
    assign wb_addr    = w_waddr;
    assign wb_data    = w_wdata;
    assign commit_cnt = r_commit_cnt;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we_eff),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_ra1   (ra1),
        .i_ra2   (ra2),
        .o_rd1   (rd1),
        .o_rd2   (rd2)
    );

    // Count committed writes, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_cnt <= '0;
        end else if (w_we_eff && (r_commit_cnt != {CNT_W{1'b1}})) begin
            r_commit_cnt <= r_commit_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_regfile
//  Description : Scoreboard bench for wb_regfile. Stimulus queues expected
//                values; a monitor compares them on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        RegWr, RegDst, MemToReg;
    logic [4:0]  rt, rd, ra1, ra2;
    logic [31:0] Dout, Result;
    logic [31:0] rd1, rd2, wb_data, commit_cnt;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] s_rd1, s_rd2, s_wb_data, s_commit_cnt;
    logic        s_wb_we;
    logic [4:0]  s_wb_addr;
    logic [3:0]  s_commit_cnt4;

    int total = 0;
    int bad   = 0;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .RegWr(RegWr), .RegDst(RegDst), .MemToReg(MemToReg),
        .rt(rt), .rd(rd), .Dout(Dout), .Result(Result), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .commit_cnt(commit_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .RegWr(RegWr), .RegDst(RegDst), .MemToReg(MemToReg),
        .rt(rt), .rd(rd), .Dout(Dout), .Result(Result), .ra1(ra1), .ra2(ra2),
        .rd1(s_rd1), .rd2(s_rd2), .wb_we(s_wb_we), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
        .commit_cnt(s_commit_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_RD1 = 0, K_RD2 = 1, K_WE = 2, K_ADDR = 3, K_DATA = 4, K_CNT = 5, K_CNT4 = 6;

    typedef struct {
        int          kind;
        int          tag;
        logic [31:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   tag_now = 0;

    function automatic string kname(input int k);
        case (k)
            K_RD1:   return "rd1";
            K_RD2:   return "rd2";
            K_WE:    return "wb_we";
            K_ADDR:  return "wb_addr";
            K_DATA:  return "wb_data";
            K_CNT:   return "commit_cnt";
            default: return "commit_cnt4";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_RD1:   return rd1;
            K_RD2:   return rd2;
            K_WE:    return {31'd0, wb_we};
            K_ADDR:  return {27'd0, wb_addr};
            K_DATA:  return wb_data;
            K_CNT:   return commit_cnt;
            default: return {28'd0, s_commit_cnt4};
        endcase
    endfunction

    task automatic expect_val(input int k, input logic [31:0] e);
        chk_t c;
        c.kind = k;
        c.tag  = tag_now;
        c.exp  = e;
        sb_q.push_back(c);
    endtask

    // Advance to just after the next rising edge, where new inputs are applied
    task automatic step();
        @(posedge clk);
        #1;
        tag_now++;
    endtask

    task automatic idle_inputs();
        RegWr = 0; RegDst = 0; MemToReg = 0;
        rt = 0; rd = 0; Dout = 0; Result = 0; ra1 = 0; ra2 = 0;
    endtask

    // Monitor: compare every queued expectation mid-cycle
    initial begin
        chk_t c;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                c = sb_q.pop_front();
                a = actual(c.kind);
                total++;
                if (a !== c.exp) begin
                    bad++;
                    $display("FAIL step%0d %s: got %h expected %h", c.tag, kname(c.kind), a, c.exp);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1;
        #1;
        // Write attempted during reset must not be exported
        RegWr = 1; RegDst = 1; rd = 5'd3; Result = 32'h55;
        expect_val(K_WE, 32'd0);
        step();
        idle_inputs();
        step();
        rst = 0;

        // 1: all registers read zero after reset
        expect_val(K_CNT, 32'd0);
        expect_val(K_CNT4, 32'd0);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            expect_val(K_RD1, 32'd0);
            expect_val(K_RD2, 32'd0);
            step();
        end

        // 2: write rd=5 from Result, bypass same cycle
        RegWr = 1; RegDst = 1; rd = 5'd5; rt = 5'd7; MemToReg = 0;
        Result = 32'hDEADBEEF; Dout = 32'h1111; ra1 = 5'd5; ra2 = 5'd7;
        expect_val(K_RD1, 32'hDEADBEEF);
        expect_val(K_RD2, 32'd0);
        expect_val(K_WE, 32'd1);
        expect_val(K_ADDR, 32'd5);
        expect_val(K_DATA, 32'hDEADBEEF);
        expect_val(K_CNT, 32'd0);
        step();
        RegWr = 0;
        expect_val(K_RD1, 32'hDEADBEEF);
        expect_val(K_CNT, 32'd1);
        expect_val(K_CNT4, 32'd1);
        expect_val(K_WE, 32'd0);
        step();

        // 3: write to $0 via rt, Dout selected, must be dropped
        RegWr = 1; RegDst = 0; rt = 5'd0; rd = 5'd5; MemToReg = 1;
        Dout = 32'h1234; Result = 32'h9999; ra1 = 5'd0; ra2 = 5'd5;
        expect_val(K_WE, 32'd0);
        expect_val(K_ADDR, 32'd0);
        expect_val(K_DATA, 32'h1234);
        expect_val(K_RD1, 32'd0);
        expect_val(K_RD2, 32'hDEADBEEF);
        step();
        RegWr = 0;
        expect_val(K_CNT, 32'd1);
        expect_val(K_RD1, 32'd0);
        step();

        // 4: write reg7 = A5 from Dout, then three bubble cycles
        RegWr = 1; RegDst = 0; rt = 5'd7; rd = 5'd2; MemToReg = 1;
        Dout = 32'hA5; Result = 32'hFF; ra1 = 5'd2; ra2 = 5'd7;
        expect_val(K_DATA, 32'hA5);
        expect_val(K_ADDR, 32'd7);
        expect_val(K_RD1, 32'd0);
        expect_val(K_RD2, 32'hA5);
        step();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            ra1 = 5'd7;
            expect_val(K_RD1, 32'hA5);
            expect_val(K_RD2, 32'd0);
            expect_val(K_WE, 32'd0);
            expect_val(K_CNT, 32'd2);
            step();
        end

        // 5: dual bypass, then reset with an in-flight write
        RegWr = 1; RegDst = 1; rd = 5'd9; MemToReg = 0; Result = 32'h11;
        ra1 = 5'd9; ra2 = 5'd9;
        expect_val(K_RD1, 32'h11);
        expect_val(K_RD2, 32'h11);
        expect_val(K_CNT, 32'd2);
        step();
        rst = 1; RegWr = 1; RegDst = 1; rd = 5'd9; Result = 32'h22;
        expect_val(K_WE, 32'd0);
        expect_val(K_RD1, 32'h11);
        expect_val(K_RD2, 32'h11);
        expect_val(K_CNT, 32'd3);
        expect_val(K_CNT4, 32'd3);
        step();
        rst = 0; RegWr = 0; ra1 = 5'd9; ra2 = 5'd7;
        expect_val(K_RD1, 32'd0);
        expect_val(K_RD2, 32'd0);
        expect_val(K_CNT, 32'd0);
        expect_val(K_CNT4, 32'd0);
        step();

        // 6: 17 writes, narrow counter saturates at F
        for (int i = 0; i < 17; i++) begin
            RegWr = 1; RegDst = 1; MemToReg = 0;
            rd = 5'(i + 1); Result = 32'(i) + 32'h100;
            expect_val(K_CNT, 32'(i));
            expect_val(K_CNT4, (i > 15) ? 32'd15 : 32'(i));
            step();
        end
        RegWr = 0; ra1 = 5'd17; ra2 = 5'd1;
        expect_val(K_CNT, 32'd17);
        expect_val(K_CNT4, 32'hF);
        expect_val(K_RD1, 32'h110);
        expect_val(K_RD2, 32'h100);
        step();

        // Let the monitor drain the last expectations
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
